lc3b_mem_bridge: RTL and testbench

Memory-side stage downstream of the LC-3b multi-cycle controller and datapath. It takes one 16-bit load/store request (word or byte; LDW/STW/LDB/STB) and runs it as one or two beats on an external byte-wide, variable-latency memory bus. Word accesses are little-endian: low byte at the even address, high byte at address+1. The bridge returns a registered result with a one-cycle done pulse, flags forced word alignment, and aborts a beat whose memory never answers.

---
 rtl/lc3b_mem_bridge.sv | 182 ++++++++++++++++++
 tb/tb_lc3b_mem_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_bridge.sv
// Runs one LC-3b load/store request as one or two byte beats on a variable-latency
// external memory bus, returning a registered result with a one-cycle done pulse.
module lc3b_mem_bridge #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] rdata,
   output logic        err,
   output logic        misalign,
   output logic        mem_cs_n,
   output logic        mem_we_n,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rdy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BEAT_LO = 2'd1;
   localparam logic [1:0] BEAT_HI = 2'd2;
   localparam logic [1:0] FIN     = 2'd3;

   localparam logic [7:0] WaitMaxC = 8'(WAIT_MAX);

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d, byte_q, byte_d, mis_q, mis_d;
   logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  wait_q, wait_d, wait_inc;

   logic        busy_d, done_d, err_d, misalign_d;
   logic [15:0] rdata_d;
   logic        mem_cs_n_d, mem_we_n_d;
   logic [15:0] mem_addr_d;
   logic [7:0]  mem_wdata_d;

   logic        fin, fin_err;
   logic [15:0] fin_rdata;

   assign wait_inc = wait_q + 8'd1;

   // Outputs are computed for the state being entered so every port is a flop.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      byte_d      = byte_q;
      mis_d       = mis_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      wait_d      = wait_q;
      busy_d      = busy;
      done_d      = 1'b0;
      err_d       = err;
      misalign_d  = misalign;
      rdata_d     = rdata;
      mem_cs_n_d  = mem_cs_n;
      mem_we_n_d  = mem_we_n;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      fin         = 1'b0;
      fin_err     = 1'b0;
      fin_rdata   = 16'h0000;

      case (state_q)
         IDLE: begin
            if (req) begin
               we_d        = req_we;
               byte_d      = req_byte;
               addr_d      = req_byte ? req_addr : {req_addr[15:1], 1'b0};
               mis_d       = ~req_byte & req_addr[0];
               wdata_d     = req_wdata;
               wait_d      = 8'd0;
               state_d     = BEAT_LO;
               busy_d      = 1'b1;
               mem_cs_n_d  = 1'b0;
               mem_we_n_d  = ~req_we;
               mem_addr_d  = req_byte ? req_addr : {req_addr[15:1], 1'b0};
               mem_wdata_d = req_wdata[7:0];
            end
         end
         BEAT_LO: begin
            if (mem_rdy) begin
               lo_d   = mem_rdata;
               wait_d = 8'd0;
               if (byte_q) begin
                  fin       = 1'b1;
                  fin_rdata = we_q ? 16'h0000 : {{8{mem_rdata[7]}}, mem_rdata};
               end else begin
                  // Chip select stays low; only address and data move to the high byte.
                  state_d     = BEAT_HI;
                  mem_addr_d  = addr_q | 16'h0001;
                  mem_wdata_d = wdata_q[15:8];
               end
            end else if (wait_inc == WaitMaxC) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         BEAT_HI: begin
            if (mem_rdy) begin
               fin       = 1'b1;
               fin_rdata = we_q ? 16'h0000 : {mem_rdata, lo_q};
            end else if (wait_inc == WaitMaxC) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (fin) begin
         state_d    = FIN;
         done_d     = 1'b1;
         err_d      = fin_err;
         misalign_d = mis_q;
         rdata_d    = fin_rdata;
         mem_cs_n_d = 1'b1;
         mem_we_n_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         mis_q     <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         lo_q      <= 8'h00;
         wait_q    <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         misalign  <= 1'b0;
         rdata     <= 16'h0000;
         mem_cs_n  <= 1'b1;
         mem_we_n  <= 1'b1;
         mem_addr  <= 16'h0000;
         mem_wdata <= 8'h00;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         byte_q    <= byte_d;
         mis_q     <= mis_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lo_q      <= lo_d;
         wait_q    <= wait_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         misalign  <= misalign_d;
         rdata     <= rdata_d;
         mem_cs_n  <= mem_cs_n_d;
         mem_we_n  <= mem_we_n_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// Scoreboard bench for lc3b_mem_bridge: directed requests push expected beats and results,
// monitors pop and compare as the bus and done pulses appear.
module tb_lc3b_mem_bridge;

   localparam int unsigned WaitMax = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, req_we = 1'b0, req_byte = 1'b0;
   logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
   logic        busy, done, err, misalign, mem_cs_n, mem_we_n;
   logic [15:0] rdata, mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_rdy = 1'b0;

   lc3b_mem_bridge #(.WAIT_MAX(WaitMax)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_byte(req_byte),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
      .err(err), .misalign(misalign), .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] rdata; logic err; logic mis; int lat; } res_t;
   typedef struct { logic we; logic [15:0] addr; logic [7:0] data; } beat_t;

   res_t        exp_q[$];
   beat_t       beat_q[$];
   logic [7:0]  mem_model [65536];
   int          n_vec = 0, n_fail = 0;
   int          cyc = 0, acc_cyc = 0, low_cyc = 0;
   int          wait_cfg = 0, beat_cyc = 0;
   bit          stuck = 1'b0;
   logic        prev_cs_n = 1'b1;
   logic [15:0] prev_addr = 16'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory: each beat waits wait_cfg cycles, then answers with the stored byte.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!mem_cs_n) begin
         if (prev_cs_n || mem_addr != prev_addr) beat_cyc = 0;
         else beat_cyc++;
      end
      prev_cs_n = mem_cs_n;
      prev_addr = mem_addr;
      mem_rdy   = !mem_cs_n && !stuck && beat_cyc >= wait_cfg;
      mem_rdata = mem_cs_n ? 8'h00 : mem_model[mem_addr];
   end

   // Bus and result monitor, sampled mid-cycle.
   always @(negedge clk) begin
      beat_t b;
      res_t  r;
      if (!mem_cs_n) low_cyc++;
      if (!mem_cs_n && mem_rdy) begin
         if (beat_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_beat: got addr %0h, expected no beat", mem_addr);
         end else begin
            b = beat_q.pop_front();
            check("beat_we", {31'h0, ~mem_we_n}, {31'h0, b.we});
            check("beat_addr", {16'h0, mem_addr}, {16'h0, b.addr});
            if (b.we) begin
               check("beat_wdata", {24'h0, mem_wdata}, {24'h0, b.data});
               mem_model[mem_addr] = mem_wdata;
            end
         end
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_done: got rdata %0h, expected no done", rdata);
         end else begin
            r = exp_q.pop_front();
            check("rdata", {16'h0, rdata}, {16'h0, r.rdata});
            check("err", {31'h0, err}, {31'h0, r.err});
            check("misalign", {31'h0, misalign}, {31'h0, r.mis});
            check("latency", cyc - acc_cyc + 1, r.lat);
            check("busy_at_done", {31'h0, busy}, 32'h1);
         end
      end
   end

   task automatic push_res(input logic [15:0] rd, input logic e, input logic m, input int lat);
      res_t r;
      r.rdata = rd; r.err = e; r.mis = m; r.lat = lat;
      exp_q.push_back(r);
   endtask

   task automatic push_beat(input logic we, input logic [15:0] a, input logic [7:0] d);
      beat_t b;
      b.we = we; b.addr = a; b.data = d;
      beat_q.push_back(b);
   endtask

   // Called at a negedge with the bridge idle; returns at the negedge of cycle 1.
   task automatic issue(input logic we, input logic byt, input logic [15:0] a,
                        input logic [15:0] wd);
      req = 1'b1; req_we = we; req_byte = byt; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++; n_fail++;
         $display("FAIL %s_timeout: got busy stuck high, expected idle", name);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h0);
      check({tag, "_err"}, {31'h0, err}, 32'h0);
      check({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
      check({tag, "_rdata"}, {16'h0, rdata}, 32'h0);
      check({tag, "_cs_n"}, {31'h0, mem_cs_n}, 32'h1);
      check({tag, "_we_n"}, {31'h0, mem_we_n}, 32'h1);
      check({tag, "_addr"}, {16'h0, mem_addr}, 32'h0);
      check({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      mem_model[16'h3000] = 8'h34;
      mem_model[16'h3001] = 8'h12;
      mem_model[16'h4001] = 8'h9C;
      mem_model[16'h5000] = 8'h11;
      mem_model[16'h5001] = 8'h22;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Word load, zero wait
      push_beat(1'b0, 16'h3000, 8'h00);
      push_beat(1'b0, 16'h3001, 8'h00);
      push_res(16'h1234, 1'b0, 1'b0, 3);
      issue(1'b0, 1'b0, 16'h3000, 16'h0000);
      wait_idle("word_load");

      // Byte loads, sign extension both ways
      push_beat(1'b0, 16'h4001, 8'h00);
      push_res(16'hFF9C, 1'b0, 1'b0, 2);
      issue(1'b0, 1'b1, 16'h4001, 16'h0000);
      wait_idle("byte_load_neg");
      mem_model[16'h4001] = 8'h5A;
      push_beat(1'b0, 16'h4001, 8'h00);
      push_res(16'h005A, 1'b0, 1'b0, 2);
      issue(1'b0, 1'b1, 16'h4001, 16'h0000);
      wait_idle("byte_load_pos");

      // Word load timeout: no beat completes, abort after WaitMax cycles of BEAT_LO
      stuck = 1'b1;
      low_cyc = 0;
      push_res(16'h0000, 1'b1, 1'b0, WaitMax + 1);
      issue(1'b0, 1'b0, 16'h5000, 16'h0000);
      wait_idle("timeout");
      check("timeout_beat_cycles", low_cyc, WaitMax);
      stuck = 1'b0;

      // Misaligned word store with two wait cycles per beat
      wait_cfg = 2;
      push_beat(1'b1, 16'h2004, 8'hEF);
      push_beat(1'b1, 16'h2005, 8'hBE);
      push_res(16'h0000, 1'b0, 1'b1, 7);
      issue(1'b1, 1'b0, 16'h2005, 16'hBEEF);
      wait_idle("word_store");
      check("store_lo_mem", {24'h0, mem_model[16'h2004]}, 32'hEF);
      check("store_hi_mem", {24'h0, mem_model[16'h2005]}, 32'hBE);

      // Byte store, zero wait, odd address is not flagged
      wait_cfg = 0;
      push_beat(1'b1, 16'h1003, 8'hA5);
      push_res(16'h0000, 1'b0, 1'b0, 2);
      issue(1'b1, 1'b1, 16'h1003, 16'h77A5);
      wait_idle("byte_store");

      // req pulsed while busy must be ignored
      wait_cfg = 2;
      push_beat(1'b0, 16'h3000, 8'h00);
      push_beat(1'b0, 16'h3001, 8'h00);
      push_res(16'h1234, 1'b0, 1'b0, 7);
      issue(1'b0, 1'b0, 16'h3000, 16'h0000);
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 16'h6000; req_wdata = 16'h00AA;
      @(negedge clk);
      req = 1'b0;
      wait_idle("busy_req");
      repeat (6) @(negedge clk);
      check("busy_req_no_extra", {31'h0, busy}, 32'h0);

      // Async reset during BEAT_HI
      wait_cfg = 3;
      push_beat(1'b0, 16'h5000, 8'h00);
      push_res(16'h2211, 1'b0, 1'b0, 9);
      issue(1'b0, 1'b0, 16'h5000, 16'h0000);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_cs_n && mem_addr[0]) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reached_beat_hi", {31'h0, hit}, 32'h1);
      exp_q.delete();
      beat_q.delete();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midbeat_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_reset_idle", {31'h0, busy}, 32'h0);

      check("results_left", exp_q.size(), 0);
      check("beats_left", beat_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
